// File: rtl/lif_neuron_array.sv
// lif_neuron_array: array of independent integrate-and-fire neurons.
// Mode 0 divides rate via accumulator carry-out; mode 1 is a threshold neuron
// with reset-to-zero and a refractory window. Spikes are registered (1-cycle latency).
// Optional leak in mode 1 is compiled in with `define LIF_LEAK_EN.

module lif_neuron_array #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int REFRACT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] w,
  input  logic [WIDTH-1:0]          threshold,
  input  logic [WIDTH-1:0]          leak,
  output logic [CHANNELS-1:0]       spike
);

  // Refractory counter must hold REFRACT; keep at least one bit so REFRACT=0 still builds.
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACT);

`ifndef LIF_LEAK_EN
  // Leak input is present on the port list but has no function in this build.
  logic unused_leak;
  assign unused_leak = ^leak;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
    logic [WIDTH-1:0] potential;
    logic [WIDTH-1:0] pot_nxt;
    logic [WIDTH-1:0] w_ch;
    logic [WIDTH-1:0] pl;
    logic [WIDTH:0]   sum;
    logic [RW-1:0]    refr;
    logic [RW-1:0]    refr_nxt;
    logic             spk_q;
    logic             spk_nxt;

    assign w_ch = w[i*WIDTH +: WIDTH];

`ifdef LIF_LEAK_EN
    // Leak saturates at zero so the potential never wraps below zero.
    assign pl = (potential > leak) ? (potential - leak) : '0;
`else
    assign pl = potential;
`endif

    // Next-state for one channel: divider in mode 0, threshold/refractory in mode 1.
    always_comb begin
      pot_nxt  = potential;
      refr_nxt = refr;
      spk_nxt  = 1'b0;
      sum      = '0;
      if (en) begin
        if (!mode) begin
          // Carry-out of the accumulator is the spike; refractory does not apply.
          sum      = {1'b0, potential} + {1'b0, w_ch};
          pot_nxt  = sum[WIDTH-1:0];
          spk_nxt  = sum[WIDTH];
          refr_nxt = '0;
        end else if (refr != '0) begin
          // Refractory step: input is discarded, potential stays at its reset value.
          refr_nxt = refr - RW'(1);
        end else begin
          sum = {1'b0, pl} + {1'b0, w_ch};
          if (sum >= {1'b0, threshold}) begin
            spk_nxt  = 1'b1;
            pot_nxt  = '0;
            refr_nxt = REFR_LOAD;
          end else begin
            // sum < threshold here, so the top bit is always zero.
            pot_nxt = sum[WIDTH-1:0];
          end
        end
      end
    end

    // Channel state and registered spike, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        potential <= '0;
        refr      <= '0;
        spk_q     <= 1'b0;
      end else begin
        potential <= pot_nxt;
        refr      <= refr_nxt;
        spk_q     <= spk_nxt;
      end
    end

    assign spike[i] = spk_q;
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: divider rate, threshold/refractory,
// zero threshold, enable gating, asynchronous reset and the optional leak.
// A second instance with REFRACT=0 covers the no-refractory case.

module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] w = '0;
  logic [7:0]  threshold = '0;
  logic [7:0]  leak = '0;
  logic [3:0]  spike;
  logic [3:0]  spike_r0;

  int tests_run = 0;
  int fails = 0;

  lif_neuron_array #(.WIDTH(8), .CHANNELS(4), .REFRACT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w),
    .threshold(threshold), .leak(leak), .spike(spike)
  );

  lif_neuron_array #(.WIDTH(8), .CHANNELS(4), .REFRACT(0)) dut_r0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w),
    .threshold(threshold), .leak(leak), .spike(spike_r0)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (spike !== 4'h0) begin fails++; $display("FAIL reset_spike got %h want 0", spike); end
    tests_run++;
    if (dut.gen_ch[0].potential !== 8'd0) begin fails++; $display("FAIL reset_pot0 got %0d want 0", dut.gen_ch[0].potential); end
    tests_run++;
    if (dut.gen_ch[3].potential !== 8'd0) begin fails++; $display("FAIL reset_pot3 got %0d want 0", dut.gen_ch[3].potential); end
    tests_run++;
    if (dut.gen_ch[0].refr !== 2'd0) begin fails++; $display("FAIL reset_refr0 got %0d want 0", dut.gen_ch[0].refr); end
    rst = 1'b0;
  endtask

  task automatic test_mode0_rate();
    bit         exp_s [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_p [5] = '{8'd191, 8'd126, 8'd61, 8'd252, 8'd187};
    int cnt0 = 0;
    int cnt1 = 0;
    do_reset();
    mode = 1'b0;
    w = {8'd0, 8'd0, 8'd0, 8'd191};
    en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (spike[0]) cnt0++;
      if (spike[1]) cnt1++;
      if (k < 5) begin
        tests_run++;
        if (spike[0] !== exp_s[k]) begin fails++; $display("FAIL m0_spike step %0d got %b want %b", k + 1, spike[0], exp_s[k]); end
        tests_run++;
        if (dut.gen_ch[0].potential !== exp_p[k]) begin fails++; $display("FAIL m0_pot step %0d got %0d want %0d", k + 1, dut.gen_ch[0].potential, exp_p[k]); end
      end
    end
    en = 1'b0;
    tests_run++;
    if (cnt0 != 191) begin fails++; $display("FAIL m0_rate got %0d want 191", cnt0); end
    tests_run++;
    if (cnt1 != 0) begin fails++; $display("FAIL m0_w0_silent got %0d want 0", cnt1); end
  endtask

  task automatic test_threshold_refract();
    logic [7:0] exp_p [11] = '{8'd30, 8'd60, 8'd90, 8'd0, 8'd0, 8'd0, 8'd0, 8'd30, 8'd60, 8'd90, 8'd0};
    logic       exp_s;
    do_reset();
    mode = 1'b1;
    threshold = 8'd100;
    w = {8'd0, 8'd0, 8'd0, 8'd30};
    en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      exp_s = (k == 3 || k == 10);
      tests_run++;
      if (spike[0] !== exp_s) begin fails++; $display("FAIL m1_spike step %0d got %b want %b", k + 1, spike[0], exp_s); end
      tests_run++;
      if (dut.gen_ch[0].potential !== exp_p[k]) begin fails++; $display("FAIL m1_pot step %0d got %0d want %0d", k + 1, dut.gen_ch[0].potential, exp_p[k]); end
    end
    en = 1'b0;
  endtask

  task automatic test_threshold_zero();
    logic [3:0] exp_main;
    do_reset();
    mode = 1'b1;
    threshold = 8'd0;
    w = {8'd5, 8'd0, 8'd200, 8'd1};
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_main = (k % 4 == 0) ? 4'hF : 4'h0;
      tests_run++;
      if (spike !== exp_main) begin fails++; $display("FAIL thr0_refr3 step %0d got %h want %h", k + 1, spike, exp_main); end
      tests_run++;
      if (spike_r0 !== 4'hF) begin fails++; $display("FAIL thr0_refr0 step %0d got %h want f", k + 1, spike_r0); end
    end
    en = 1'b0;
  endtask

  task automatic test_enable_gating();
    bit         exp_s [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] exp_p [3] = '{8'd61, 8'd252, 8'd187};
    do_reset();
    mode = 1'b0;
    w = {8'd0, 8'd0, 8'd0, 8'd191};
    en = 1'b1;
    tick();
    tick();
    tests_run++;
    if (dut.gen_ch[0].potential !== 8'd126) begin fails++; $display("FAIL gate_pre got %0d want 126", dut.gen_ch[0].potential); end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if (spike !== 4'h0) begin fails++; $display("FAIL gate_spike cycle %0d got %h want 0", k, spike); end
      tests_run++;
      if (dut.gen_ch[0].potential !== 8'd126) begin fails++; $display("FAIL gate_hold cycle %0d got %0d want 126", k, dut.gen_ch[0].potential); end
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (spike[0] !== exp_s[k]) begin fails++; $display("FAIL gate_resume_spike %0d got %b want %b", k, spike[0], exp_s[k]); end
      tests_run++;
      if (dut.gen_ch[0].potential !== exp_p[k]) begin fails++; $display("FAIL gate_resume_pot %0d got %0d want %0d", k, dut.gen_ch[0].potential, exp_p[k]); end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    bit         exp_s [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_p [5] = '{8'd191, 8'd126, 8'd61, 8'd252, 8'd187};
    do_reset();
    mode = 1'b0;
    w = {8'd0, 8'd0, 8'd0, 8'd191};
    en = 1'b1;
    tick();
    tick();
    tests_run++;
    if (spike[0] !== 1'b1) begin fails++; $display("FAIL arst_pre_spike got %b want 1", spike[0]); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (spike !== 4'h0) begin fails++; $display("FAIL arst_spike got %h want 0", spike); end
    tests_run++;
    if (dut.gen_ch[0].potential !== 8'd0) begin fails++; $display("FAIL arst_pot got %0d want 0", dut.gen_ch[0].potential); end
    #2;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests_run++;
      if (spike[0] !== exp_s[k]) begin fails++; $display("FAIL arst_seq_spike step %0d got %b want %b", k + 1, spike[0], exp_s[k]); end
      tests_run++;
      if (dut.gen_ch[0].potential !== exp_p[k]) begin fails++; $display("FAIL arst_seq_pot step %0d got %0d want %0d", k + 1, dut.gen_ch[0].potential, exp_p[k]); end
    end
    en = 1'b0;
  endtask

  task automatic test_leak();
    int first = 0;
    int want;
`ifdef LIF_LEAK_EN
    int cnt = 0;
    do_reset();
    mode = 1'b1;
    threshold = 8'd200;
    w = {8'd0, 8'd0, 8'd0, 8'd10};
    leak = 8'd10;
    en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      tick();
      if (spike[0]) cnt++;
    end
    en = 1'b0;
    tests_run++;
    if (cnt != 0) begin fails++; $display("FAIL leak_balanced got %0d spikes want 0", cnt); end
    want = 33;
`else
    want = 20;
`endif
    do_reset();
    mode = 1'b1;
    threshold = 8'd200;
    w = {8'd0, 8'd0, 8'd0, 8'd10};
    leak = 8'd4;
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (spike[0] && first == 0) first = k;
    end
    en = 1'b0;
    tests_run++;
    if (first != want) begin fails++; $display("FAIL leak_first_spike got step %0d want %0d", first, want); end
  endtask

  initial begin
    test_reset();
    test_mode0_rate();
    test_threshold_refract();
    test_threshold_zero();
    test_enable_gating();
    test_async_reset();
    test_leak();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
